fft_iter_addr_gen: RTL and testbench

//   Sequencer/address generator for the in-place radix-2 DIT iterative FFT core.

---
 rtl/fft_iter_addr_gen.sv | 165 ++++++++++++++++
 tb/tb_fft_iter_addr_gen.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fft_iter_addr_gen.sv
// Sequencer/address generator for an in-place radix-2 DIT iterative FFT.
// Issues butterfly read pairs and twiddle indices, then the matching delayed write-backs.
module fft_iter_addr_gen #(
    parameter  int AWL      = 5,
    parameter  int BFLY_LAT = 4,
    localparam int NW       = $clog2(AWL + 1)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           EN,
    input  logic           START,
    input  logic [NW-1:0]  i_NLOG2,
    input  logic           i_INV,
    output logic [AWL-1:0] o_RD_A_ADDR,
    output logic [AWL-1:0] o_RD_B_ADDR,
    output logic           o_RD_VALID,
    output logic [AWL-2:0] o_TW_ADDR,
    output logic           o_TW_CONJ,
    output logic [AWL-1:0] o_WR_A_ADDR,
    output logic [AWL-1:0] o_WR_B_ADDR,
    output logic           o_WR_EN,
    output logic [NW-1:0]  o_STAGE,
    output logic           o_RAM_BLOCK,
    output logic           o_DONE
);

    localparam int WW  = (BFLY_LAT > 1) ? $clog2(BFLY_LAT) : 1;
    localparam int TWW = AWL - 1;

    typedef enum logic [1:0] {IDLE, RUN, GAP, FIN} state_t;

    typedef struct packed {
        logic [AWL-1:0] a;
        logic [AWL-1:0] b;
        logic           v;
    } wb_t;

    state_t         state, state_nxt;
    logic [AWL-1:0] k, k_nxt, k_last;
    logic [NW-1:0]  s, s_nxt, l, l_nxt, l_samp;
    logic [WW-1:0]  w, w_nxt;
    logic           inv, inv_nxt;
    logic [AWL-1:0] rd_a, rd_b;
    logic [TWW-1:0] rd_tw;
    wb_t [BFLY_LAT-1:0] dl;

    function automatic logic [AWL-1:0] lo_mask(input logic [NW-1:0] st);
        return (AWL'(1) << st) - AWL'(1);
    endfunction

    // Top address: insert a zero at bit s of k; bottom is the same with bit s set.
    function automatic logic [AWL-1:0] addr_a(input logic [AWL-1:0] kk, input logic [NW-1:0] st);
        return ((kk >> st) << (st + NW'(1))) | (kk & lo_mask(st));
    endfunction

    // Twiddle index scaled into the full 2^AWL-point table.
    function automatic logic [TWW-1:0] addr_tw(input logic [AWL-1:0] kk, input logic [NW-1:0] st);
        return TWW'(kk & lo_mask(st)) << (NW'(AWL - 1) - st);
    endfunction

    always_comb begin
        if (i_NLOG2 == '0)
            l_samp = NW'(1);
        else if (i_NLOG2 > NW'(AWL))
            l_samp = NW'(AWL);
        else
            l_samp = i_NLOG2;
    end

    assign k_last = (AWL'(1) << (l - NW'(1))) - AWL'(1);

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        s_nxt     = s;
        w_nxt     = w;
        l_nxt     = l;
        inv_nxt   = inv;
        if (EN) begin
            case (state)
                IDLE: if (START) begin
                    state_nxt = RUN;
                    k_nxt     = '0;
                    s_nxt     = '0;
                    w_nxt     = '0;
                    l_nxt     = l_samp;
                    inv_nxt   = i_INV;
                end
                RUN: begin
                    if (k == k_last) begin
                        state_nxt = GAP;
                        w_nxt     = '0;
                    end else begin
                        k_nxt = k + AWL'(1);
                    end
                end
                GAP: begin
                    if (w == WW'(BFLY_LAT - 1)) begin
                        if (s == l - NW'(1)) begin
                            state_nxt = FIN;
                        end else begin
                            state_nxt = RUN;
                            s_nxt     = s + NW'(1);
                            k_nxt     = '0;
                        end
                    end else begin
                        w_nxt = w + WW'(1);
                    end
                end
                FIN:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            k     <= '0;
            s     <= '0;
            w     <= '0;
            l     <= NW'(1);
            inv   <= 1'b0;
            rd_a  <= '0;
            rd_b  <= '0;
            rd_tw <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            s     <= s_nxt;
            w     <= w_nxt;
            l     <= l_nxt;
            inv   <= inv_nxt;
            // Registered read addresses track the counters' next values.
            if (EN) begin
                rd_a  <= addr_a(k_nxt, s_nxt);
                rd_b  <= addr_a(k_nxt, s_nxt) | (AWL'(1) << s_nxt);
                rd_tw <= addr_tw(k_nxt, s_nxt);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            dl <= '0;
        end else if (EN) begin
            dl[0] <= '{a: rd_a, b: rd_b, v: (state == RUN)};
            for (int i = 1; i < BFLY_LAT; i++)
                dl[i] <= dl[i-1];
        end
    end

    assign o_RD_A_ADDR = rd_a;
    assign o_RD_B_ADDR = rd_b;
    assign o_RD_VALID  = EN && (state == RUN);
    assign o_TW_ADDR   = rd_tw;
    assign o_TW_CONJ   = inv;
    assign o_WR_A_ADDR = dl[BFLY_LAT-1].a;
    assign o_WR_B_ADDR = dl[BFLY_LAT-1].b;
    assign o_WR_EN     = EN && dl[BFLY_LAT-1].v;
    assign o_STAGE     = s;
    assign o_RAM_BLOCK = (state != IDLE);
    assign o_DONE      = EN && (state == FIN);

endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// Directed bench for fft_iter_addr_gen with AWL=3, BFLY_LAT=2.
module tb_fft_iter_addr_gen;

    logic       CLK = 1'b0;
    logic       RST, EN, START, i_INV;
    logic [1:0] i_NLOG2;
    logic [2:0] o_RD_A_ADDR, o_RD_B_ADDR, o_WR_A_ADDR, o_WR_B_ADDR;
    logic [1:0] o_TW_ADDR, o_STAGE;
    logic       o_RD_VALID, o_TW_CONJ, o_WR_EN, o_RAM_BLOCK, o_DONE;

    int total = 0;
    int bad   = 0;

    // Hand-derived read stream for an 8-point transform.
    int ra[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int rb[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int rt[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    fft_iter_addr_gen #(.AWL(3), .BFLY_LAT(2)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .START(START),
        .i_NLOG2(i_NLOG2), .i_INV(i_INV),
        .o_RD_A_ADDR(o_RD_A_ADDR), .o_RD_B_ADDR(o_RD_B_ADDR), .o_RD_VALID(o_RD_VALID),
        .o_TW_ADDR(o_TW_ADDR), .o_TW_CONJ(o_TW_CONJ),
        .o_WR_A_ADDR(o_WR_A_ADDR), .o_WR_B_ADDR(o_WR_B_ADDR), .o_WR_EN(o_WR_EN),
        .o_STAGE(o_STAGE), .o_RAM_BLOCK(o_RAM_BLOCK), .o_DONE(o_DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Read-stream position for 8-point window e (1-based): -1 if no read.
    function automatic int rd_idx(input int e);
        if (e >= 1 && e <= 18 && ((e - 1) % 6) < 4)
            return ((e - 1) / 6) * 4 + (e - 1) % 6;
        return -1;
    endfunction

    task automatic chk_l3(input int e, input logic en);
        int ri, wi;
        ri = rd_idx(e);
        wi = rd_idx(e - 2);
        chk($sformatf("l3_rdv_%0d", e), o_RD_VALID, (ri >= 0) && en);
        chk($sformatf("l3_wre_%0d", e), o_WR_EN, (wi >= 0) && en);
        chk($sformatf("l3_done_%0d", e), o_DONE, (e == 19) && en);
        chk($sformatf("l3_blk_%0d", e), o_RAM_BLOCK, (e >= 1 && e <= 19));
        if (ri >= 0) begin
            chk($sformatf("l3_rda_%0d", e), o_RD_A_ADDR, ra[ri]);
            chk($sformatf("l3_rdb_%0d", e), o_RD_B_ADDR, rb[ri]);
            chk($sformatf("l3_tw_%0d", e), o_TW_ADDR, rt[ri]);
        end
        if (wi >= 0) begin
            chk($sformatf("l3_wra_%0d", e), o_WR_A_ADDR, ra[wi]);
            chk($sformatf("l3_wrb_%0d", e), o_WR_B_ADDR, rb[wi]);
        end
        if (e >= 1 && e <= 19)
            chk($sformatf("l3_stage_%0d", e), o_STAGE, (e == 19) ? 2 : (e - 1) / 6);
    endtask

    task automatic start_run(input logic [1:0] n, input logic inv);
        tick();
        START = 1'b1; i_NLOG2 = n; i_INV = inv;
        #1;
    endtask

    initial begin
        RST = 1'b1; EN = 1'b1; START = 1'b0; i_INV = 1'b0; i_NLOG2 = 2'd0;
        tick(); tick();
        #1;
        chk("rst_rdv", o_RD_VALID, 0);
        chk("rst_wre", o_WR_EN, 0);
        chk("rst_done", o_DONE, 0);
        chk("rst_blk", o_RAM_BLOCK, 0);
        chk("rst_addr", {o_RD_A_ADDR, o_RD_B_ADDR, o_TW_ADDR, o_WR_A_ADDR, o_WR_B_ADDR}, 0);
        chk("rst_misc", {o_STAGE, o_TW_CONJ}, 0);
        RST = 1'b0;

        // Full 8-point run; a stray START in RUN must be ignored.
        start_run(2'd3, 1'b0);
        chk("l3_idle_blk", o_RAM_BLOCK, 0);
        for (int c = 1; c <= 20; c++) begin
            tick();
            START = (c == 8);
            #1;
            chk_l3(c, 1'b1);
        end
        chk("l3_conj", o_TW_CONJ, 0);

        // Smallest transform; NLOG2=0 clamps to 1.
        for (int n = 1; n >= 0; n--) begin
            start_run(2'(n), 1'b0);
            for (int c = 1; c <= 5; c++) begin
                tick();
                START = 1'b0;
                #1;
                chk($sformatf("l1_%0d_rdv_%0d", n, c), o_RD_VALID, c == 1);
                chk($sformatf("l1_%0d_wre_%0d", n, c), o_WR_EN, c == 3);
                chk($sformatf("l1_%0d_done_%0d", n, c), o_DONE, c == 4);
                if (c == 1)
                    chk($sformatf("l1_%0d_rd", n), {o_RD_A_ADDR, o_RD_B_ADDR, o_TW_ADDR}, {3'd0, 3'd1, 2'd0});
                if (c == 3)
                    chk($sformatf("l1_%0d_wr", n), {o_WR_A_ADDR, o_WR_B_ADDR}, {3'd0, 3'd1});
            end
        end

        // 4-point inverse transform.
        start_run(2'd2, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            tick();
            START = 1'b0;
            #1;
            chk($sformatf("l2_rdv_%0d", c), o_RD_VALID, (c == 1 || c == 2 || c == 5 || c == 6));
            chk($sformatf("l2_done_%0d", c), o_DONE, c == 9);
            if (c == 1) chk("l2_conj", o_TW_CONJ, 1);
            if (c == 2) chk("l2_s0k1", {o_RD_A_ADDR, o_RD_B_ADDR, o_TW_ADDR}, {3'd2, 3'd3, 2'd0});
            if (c == 5) chk("l2_s1k0", {o_RD_A_ADDR, o_RD_B_ADDR, o_TW_ADDR}, {3'd0, 3'd2, 2'd0});
            if (c == 6) chk("l2_s1k1", {o_RD_A_ADDR, o_RD_B_ADDR, o_TW_ADDR}, {3'd1, 3'd3, 2'd2});
        end

        // Three EN-low cycles in RUN shift everything by three.
        start_run(2'd3, 1'b0);
        for (int t = 1; t <= 23; t++) begin
            tick();
            START = 1'b0;
            EN = !(t >= 3 && t <= 5);
            #1;
            chk_l3((t < 3) ? t : ((t <= 5) ? 3 : t - 3), EN);
        end
        EN = 1'b1;

        // Reset during the first GAP aborts and drops pending writes.
        start_run(2'd3, 1'b0);
        for (int t = 1; t <= 9; t++) begin
            tick();
            START = 1'b0;
            RST = (t == 5);
            #1;
            if (t < 5) chk_l3(t, 1'b1);
            if (t >= 6) begin
                chk($sformatf("rg_blk_%0d", t), o_RAM_BLOCK, 0);
                chk($sformatf("rg_wre_%0d", t), o_WR_EN, 0);
                chk($sformatf("rg_rdv_%0d", t), o_RD_VALID, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
